// File: rtl/motor_drive_pkg.sv
// Shared types and sizing helpers for the N-channel motor drive.
package motor_drive_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DEAD1 = 2'd1,
      DEAD2 = 2'd2
   } dir_state_e;

   // Largest duty word; also one more than the last PWM count value.
   function automatic int pwm_max(input int w);
      return (1 << w) - 1;
   endfunction

   // Bits needed for a counter running 0..n-1, never less than one.
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/motor_ch.sv
// One motor channel: duty latch, PWM counter, reversal dead-time FSM and hall edge counter.
module motor_ch
   import motor_drive_pkg::*;
#(
   parameter int PWM_W    = 8,
   parameter int DEADTIME = 1000,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             tick_i,
   input  logic             gate_end_i,
   input  logic [PWM_W-1:0] duty_i,
   input  logic             enable_i,
   input  logic             dir_req_i,
   input  logic             sa_i,
   output logic             en_o,
   output logic             dir_o,
   output dir_state_e       state_o,
   output logic [CNT_W-1:0] pulse_cnt_o
);

   localparam int DW = cnt_w(DEADTIME);
   localparam logic [PWM_W-1:0] PWM_LAST  = PWM_W'(pwm_max(PWM_W) - 1);
   localparam logic [DW-1:0]    DEAD_LOAD = DW'(DEADTIME - 1);
   localparam logic [CNT_W-1:0] CNT_SAT   = '1;

   logic [PWM_W-1:0] duty_q, pwm_cnt_q;
   dir_state_e       state_q, state_d;
   logic [DW-1:0]    dead_cnt_q, dead_cnt_d;
   logic             dir_q, dir_d;
   logic             en_q, en_d;
   logic [2:0]       sync_q;
   logic [CNT_W-1:0] edge_cnt_q, edge_inc, pulse_q;
   logic             pwm_raw, rise;

   always_comb begin
      state_d    = state_q;
      dead_cnt_d = dead_cnt_q;
      dir_d      = dir_q;
      case (state_q)
         RUN: begin
            if (dir_req_i != dir_q) begin
               state_d    = DEAD1;
               dead_cnt_d = DEAD_LOAD;
            end
         end
         DEAD1: begin
            if (dead_cnt_q == '0) begin
               dir_d      = dir_req_i;
               state_d    = DEAD2;
               dead_cnt_d = DEAD_LOAD;
            end else begin
               dead_cnt_d = dead_cnt_q - DW'(1);
            end
         end
         DEAD2: begin
            if (dead_cnt_q == '0) begin
               // A request that flipped again during dead time starts a fresh sequence.
               state_d    = (dir_req_i != dir_q) ? DEAD1 : RUN;
               dead_cnt_d = DEAD_LOAD;
            end else begin
               dead_cnt_d = dead_cnt_q - DW'(1);
            end
         end
         default: state_d = RUN;
      endcase
   end

   // Gating on the next state blanks the bridge on the same edge the FSM leaves RUN.
   assign pwm_raw  = (pwm_cnt_q < duty_q);
   assign en_d     = pwm_raw & enable_i & (state_d == RUN);
   assign rise     = sync_q[1] & ~sync_q[2];
   assign edge_inc = (rise && (edge_cnt_q != CNT_SAT)) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         duty_q     <= '0;
         pwm_cnt_q  <= '0;
         state_q    <= RUN;
         dead_cnt_q <= '0;
         dir_q      <= 1'b0;
         en_q       <= 1'b0;
         sync_q     <= '0;
         edge_cnt_q <= '0;
         pulse_q    <= '0;
      end else begin
         state_q    <= state_d;
         dead_cnt_q <= dead_cnt_d;
         dir_q      <= dir_d;
         en_q       <= en_d;
         sync_q     <= {sync_q[1:0], sa_i};
         if (tick_i) begin
            pwm_cnt_q <= (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + PWM_W'(1);
            if (pwm_cnt_q == '0) duty_q <= duty_i;
         end
         if (gate_end_i) begin
            pulse_q    <= edge_inc;
            edge_cnt_q <= '0;
         end else begin
            edge_cnt_q <= edge_inc;
         end
      end
   end

   assign en_o        = en_q;
   assign dir_o       = dir_q;
   assign state_o     = state_q;
   assign pulse_cnt_o = pulse_q;

endmodule

// File: rtl/motor_drive_nch.sv
// N-channel PWM/direction/hall block; owns the shared PWM prescaler and speed gate timer.
module motor_drive_nch
   import motor_drive_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int PWM_W       = 8,
   parameter int PRESCALE    = 4,
   parameter int DEADTIME    = 1000,
   parameter int GATE_CYCLES = 10000000,
   parameter int CNT_W       = 16
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [NUM_CH*PWM_W-1:0] duty,
   input  logic [NUM_CH-1:0]       enable,
   input  logic [NUM_CH-1:0]       dir_req,
   input  logic [NUM_CH-1:0]       sa,
   output logic [NUM_CH-1:0]       en_o,
   output logic [NUM_CH-1:0]       dir_o,
   output logic [NUM_CH-1:0]       reversing,
   output logic [NUM_CH*CNT_W-1:0] pulse_cnt,
   output logic                    cnt_valid
);

   localparam int PW = cnt_w(PRESCALE);
   localparam int GW = cnt_w(GATE_CYCLES);
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
   localparam logic [GW-1:0] GATE_LAST  = GW'(GATE_CYCLES - 1);

   logic [PW-1:0] presc_q;
   logic [GW-1:0] gate_q;
   logic          cnt_valid_q;
   logic          tick, gate_end;
   dir_state_e    ch_state [NUM_CH];

   assign tick     = (presc_q == PRESC_LAST);
   assign gate_end = (gate_q == GATE_LAST);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         presc_q     <= '0;
         gate_q      <= '0;
         cnt_valid_q <= 1'b0;
      end else begin
         presc_q     <= tick ? '0 : presc_q + PW'(1);
         gate_q      <= gate_end ? '0 : gate_q + GW'(1);
         // Strobe lines up with the cycle the channels present their new counts.
         cnt_valid_q <= gate_end;
      end
   end

   assign cnt_valid = cnt_valid_q;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      motor_ch #(
         .PWM_W    (PWM_W),
         .DEADTIME (DEADTIME),
         .CNT_W    (CNT_W)
      ) u_ch (
         .clk         (clk),
         .resetn      (resetn),
         .tick_i      (tick),
         .gate_end_i  (gate_end),
         .duty_i      (duty[i*PWM_W +: PWM_W]),
         .enable_i    (enable[i]),
         .dir_req_i   (dir_req[i]),
         .sa_i        (sa[i]),
         .en_o        (en_o[i]),
         .dir_o       (dir_o[i]),
         .state_o     (ch_state[i]),
         .pulse_cnt_o (pulse_cnt[i*CNT_W +: CNT_W])
      );
      assign reversing[i] = (ch_state[i] != RUN);
   end

endmodule

// File: tb/tb_motor_drive_nch.sv
// Self-checking bench for motor_drive_nch: PWM duty, reversal dead time, hall counting, reset.
module tb_motor_drive_nch;

   localparam int NUM_CH      = 2;
   localparam int PWM_W       = 4;
   localparam int PRESCALE    = 2;
   localparam int DEADTIME    = 8;
   localparam int GATE_CYCLES = 200;
   localparam int CNT_W       = 3;

   logic                    clk = 1'b0;
   logic                    resetn;
   logic [NUM_CH*PWM_W-1:0] duty;
   logic [NUM_CH-1:0]       enable, dir_req, sa;
   logic [NUM_CH-1:0]       en_o, dir_o, reversing;
   logic [NUM_CH*CNT_W-1:0] pulse_cnt;
   logic                    cnt_valid;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_q[$];

   motor_drive_nch #(
      .NUM_CH      (NUM_CH),
      .PWM_W       (PWM_W),
      .PRESCALE    (PRESCALE),
      .DEADTIME    (DEADTIME),
      .GATE_CYCLES (GATE_CYCLES),
      .CNT_W       (CNT_W)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .duty      (duty),
      .enable    (enable),
      .dir_req   (dir_req),
      .sa        (sa),
      .en_o      (en_o),
      .dir_o     (dir_o),
      .reversing (reversing),
      .pulse_cnt (pulse_cnt),
      .cnt_valid (cnt_valid)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #500us;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", tag, got, exp);
      end
   endtask

   task automatic sb_check(input string tag, input logic [31:0] got);
      if (exp_q.size() == 0) check_eq({tag, "_noexp"}, 32'(exp_q.size()), 32'd1);
      else check_eq(tag, got, exp_q.pop_front());
   endtask

   // ---------------- driver helpers ----------------
   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_duty(input int ch, input int v);
      duty[ch*PWM_W +: PWM_W] = PWM_W'(v);
   endtask

   task automatic count_high(input int n, output int hi);
      hi = 0;
      repeat (n) begin
         @(negedge clk);
         hi += int'(en_o[0]);
      end
   endtask

   task automatic wait_valid(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (cnt_valid) seen = 1'b1;
      end
   endtask

   task automatic hall_pulses(input int n1, input int n0);
      for (int i = 0; i < n1; i++) begin
         sa[1] = 1'b1;
         sa[0] = (i < n0);
         wait_neg(4);
         sa = '0;
         wait_neg(4);
      end
   endtask

   function automatic logic [31:0] pcnt(input int ch);
      return 32'(pulse_cnt[ch*CNT_W +: CNT_W]);
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      int hi, h2;
      bit seen, found, prev;
      resetn = 1'b0; duty = '0; enable = '0; dir_req = '0; sa = '0;
      wait_neg(3);
      check_eq("rst_en",    32'(en_o),      32'd0);
      check_eq("rst_dir",   32'(dir_o),     32'd0);
      check_eq("rst_rev",   32'(reversing), 32'd0);
      check_eq("rst_pcnt",  32'(pulse_cnt), 32'd0);
      check_eq("rst_valid", 32'(cnt_valid), 32'd0);
      resetn = 1'b1;

      // Duty: any 30-clk window spans exactly one 15-tick period.
      enable = 2'b01;
      set_duty(0, 5);  exp_q.push_back(10);
      wait_neg(60); count_high(30, hi); sb_check("duty5", 32'(hi));
      set_duty(0, 0);  exp_q.push_back(0);
      wait_neg(60); count_high(30, hi); sb_check("duty0", 32'(hi));
      set_duty(0, 15); exp_q.push_back(30);
      wait_neg(60); count_high(30, hi); sb_check("duty15", 32'(hi));

      // Duty change mid-period: current period keeps old duty.
      set_duty(0, 5);
      wait_neg(60);
      exp_q.push_back(10); exp_q.push_back(20);
      found = 1'b0; prev = en_o[0];
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (en_o[0] && !prev) found = 1'b1;
         prev = en_o[0];
      end
      check_eq("mid_sync", 32'(found), 32'd1);
      count_high(5, hi); hi += 1;
      set_duty(0, 10);
      count_high(24, h2); sb_check("mid_cur", 32'(hi + h2));
      count_high(30, hi); sb_check("mid_next", 32'(hi));

      // Enable drop takes effect on the next edge.
      set_duty(0, 15); set_duty(1, 15);
      wait_neg(60);
      check_eq("en_pre", 32'(en_o[0]), 32'd1);
      enable[0] = 1'b0;
      wait_neg(1);
      check_eq("en_drop", 32'(en_o[0]), 32'd0);
      enable = 2'b11;
      wait_neg(40);
      check_eq("run_both", 32'(en_o), 32'd3);

      // Reversal 0->1 on ch0.
      dir_req[0] = 1'b1;
      wait_neg(1);
      check_eq("rev_start", 32'(reversing), 32'd1);
      check_eq("rev_en_low", 32'(en_o), 32'd2);
      wait_neg(7);
      check_eq("dir_hold", 32'(dir_o), 32'd0);
      wait_neg(1);
      check_eq("dir_flip", 32'(dir_o), 32'd1);
      check_eq("dead2_rev", 32'(reversing), 32'd1);
      wait_neg(7);
      check_eq("dead2_low", 32'(en_o), 32'd2);
      wait_neg(1);
      check_eq("en_resume", 32'(en_o), 32'd3);
      check_eq("rev_done", 32'(reversing), 32'd0);

      dir_req[0] = 1'b0;
      wait_neg(20);
      check_eq("back_zero", 32'(dir_o), 32'd0);

      // Toggle back during DEAD2 re-enters DEAD1.
      dir_req[0] = 1'b1;
      wait_neg(9);
      check_eq("tog_flip", 32'(dir_o), 32'd1);
      wait_neg(2);
      dir_req[0] = 1'b0;
      wait_neg(6);
      check_eq("tog_redead", 32'(reversing), 32'd1);
      check_eq("tog_dir1", 32'(dir_o), 32'd1);
      wait_neg(8);
      check_eq("tog_return", 32'(dir_o), 32'd0);
      wait_neg(7);
      check_eq("tog_dead2", 32'(reversing), 32'd1);
      wait_neg(1);
      check_eq("tog_run", 32'(reversing), 32'd0);
      check_eq("tog_en", 32'(en_o), 32'd3);

      // Hall counting; ch1 reverses in the background.
      dir_req[1] = 1'b1;
      wait_valid(250, seen);
      check_eq("win_sync", 32'(seen), 32'd1);
      exp_q.push_back(3); exp_q.push_back(7);
      hall_pulses(7, 3);
      wait_valid(250, seen);
      check_eq("win1_valid", 32'(seen), 32'd1);
      sb_check("win1_ch0", pcnt(0));
      sb_check("win1_ch1", pcnt(1));
      wait_neg(1);
      check_eq("valid_1cyc", 32'(cnt_valid), 32'd0);

      // ch0 edge lands in the gate-end cycle; raw ch1 rise at gate end lands next window.
      exp_q.push_back(1); exp_q.push_back(2);
      hall_pulses(2, 0);
      wait_neg(180);
      sa[0] = 1'b1;
      wait_neg(2);
      sa[1] = 1'b1;
      wait_neg(1);
      check_eq("win2_valid", 32'(cnt_valid), 32'd1);
      sb_check("win2_ch0", pcnt(0));
      sb_check("win2_ch1", pcnt(1));
      exp_q.push_back(0); exp_q.push_back(1);
      wait_neg(2);
      sa = '0;
      wait_valid(250, seen);
      check_eq("win3_valid", 32'(seen), 32'd1);
      sb_check("win3_ch0", pcnt(0));
      sb_check("win3_ch1", pcnt(1));

      // Saturation at 2^CNT_W-1.
      exp_q.push_back(0); exp_q.push_back(7);
      hall_pulses(12, 0);
      wait_valid(250, seen);
      check_eq("win4_valid", 32'(seen), 32'd1);
      sb_check("sat_ch0", pcnt(0));
      sb_check("sat_ch1", pcnt(1));

      // Async reset mid-reversal.
      dir_req[0] = 1'b1;
      wait_neg(3);
      check_eq("pre_rst_rev", 32'(reversing), 32'd1);
      check_eq("pre_rst_dir", 32'(dir_o), 32'd2);
      resetn = 1'b0;
      #1;
      check_eq("arst_en",   32'(en_o),      32'd0);
      check_eq("arst_dir",  32'(dir_o),     32'd0);
      check_eq("arst_rev",  32'(reversing), 32'd0);
      check_eq("arst_pcnt", 32'(pulse_cnt), 32'd0);
      wait_neg(2);
      resetn = 1'b1;
      wait_neg(1);
      check_eq("restart_rev", 32'(reversing), 32'd3);
      exp_q.push_back(0);
      wait_neg(198);
      check_eq("first_gate_early", 32'(cnt_valid), 32'd0);
      wait_neg(1);
      check_eq("first_gate", 32'(cnt_valid), 32'd1);
      sb_check("first_pcnt", 32'(pulse_cnt));
      check_eq("restart_dir", 32'(dir_o), 32'd3);

      check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/motor_drive_nch.md
Name: motor_drive_nch

Overview:
Parametrised N-channel successor to the single-motor PWM/direction/hall path in the board top level. Each channel:
- generates a glitch-free PWM enable from a duty word;
- enforces a dead-time sequence whenever the requested direction changes;
- counts synchronised hall-sensor (SA) rising edges over a shared gate window, giving a speed sample for the PID firmware.

The block sits between the processor's GPIO/control registers and the motor headers.

Parameters:
NUM_CH, 2, number of motor channels
PWM_W, 8, duty/PWM counter width; PWM period = 2^PWM_W-1 ticks
PRESCALE, 4, clk cycles per PWM tick (>=1)
DEADTIME, 1000, clk cycles EN is held low before and after a DIR change (>=1)
GATE_CYCLES, 10000000, clk cycles per speed-measurement window (100 ms at 100 MHz)
CNT_W, 16, width of each hall edge count (saturating)

Ports:
clk  in  1  system clock (100 MHz)
resetn  in  1  asynchronous, active-low reset
duty  in  NUM_CH*PWM_W  per-channel duty word, channel i at [i*PWM_W +: PWM_W]
enable  in  NUM_CH  per-channel run enable
dir_req  in  NUM_CH  requested direction per channel
sa  in  NUM_CH  raw hall sensor inputs (asynchronous)
en_o  out  NUM_CH  PWM enable to H-bridge
dir_o  out  NUM_CH  applied direction to H-bridge
reversing  out  NUM_CH  high while a channel is in a dead-time state
pulse_cnt  out  NUM_CH*CNT_W  last completed window edge count per channel
cnt_valid  out  1  one-cycle strobe when pulse_cnt updates

Behaviour:
- Reset (async assert, sync release): en_o=0, dir_o=0, reversing=0, pulse_cnt=0, cnt_valid=0, all counters 0, FSMs in RUN. Assertion mid-operation clears every output immediately.
- Prescaler: shared counter 0..PRESCALE-1. tick=1 when the counter equals PRESCALE-1, then it wraps.
- PWM counter, per channel, advances on tick over 0..2^PWM_W-2, then wraps to 0.
- Duty is latched into duty_q only when pwm_cnt==0 and tick; there are no mid-period changes.
- pwm_raw = (pwm_cnt < duty_q):
  - duty 0 gives constant low;
  - duty 2^PWM_W-1 gives constant high.
- Direction FSM per channel:
  - RUN: if dir_req != dir_o, go to DEAD1 and load dead_cnt=DEADTIME-1.
  - DEAD1: count down; at 0, dir_o <= dir_req (sampled that cycle), go to DEAD2, reload dead_cnt.
  - DEAD2: count down; at 0, go to DEAD1 if dir_req != dir_o, otherwise go to RUN.
  - A dir_req toggle during DEAD1/DEAD2 does not abort the sequence.
  - reversing=1 in DEAD1/DEAD2 (registered with the state).
- en_o (registered, 1-cycle latency) = pwm_raw & enable & (state==RUN). Dropping enable forces en_o low on the next clk edge. Enable has no effect on the direction FSM.
- Hall path, per channel:
  - 2-FF synchroniser, then a third flop for rising-edge detect.
  - Edge-to-count latency is 3 clk cycles after sa rises.
  - Pulses shorter than 1 clk may be missed.
- Gate timer (shared) counts 0..GATE_CYCLES-1. At terminal count, for every channel in the same cycle:
  - pulse_cnt <= edge_cnt (including an edge detected in that cycle);
  - cnt_valid=1 for that cycle;
  - edge_cnt restarts at 0.
- edge_cnt saturates at 2^CNT_W-1 (no wrap).
- The first cnt_valid occurs GATE_CYCLES cycles after reset release.

Decomposition:
- Package motor_drive_pkg:
  - direction FSM state enum {RUN, DEAD1, DEAD2};
  - localparam PWM_MAX = 2^PWM_W-1 computation helper;
  - clog2-based counter width helpers for PRESCALE, DEADTIME and GATE_CYCLES.
- Sub-module motor_ch: one channel's duty latch, PWM counter, direction FSM, synchroniser/edge counter. Instantiated NUM_CH times via generate.
- The top level holds the shared prescaler and gate timer and broadcasts tick/gate_end.

Test Plan:
- Bench parameters for all scenarios: NUM_CH=2, PWM_W=4, PRESCALE=2, DEADTIME=8, GATE_CYCLES=200.
- Duty: ch0 duty=5, enable=1 -> en_o[0] high 5 of every 15 ticks (10 of 30 clk). Duty 0 -> never high. Duty 15 -> always high after the first period boundary.
- Duty change mid-period (5->10 at pwm_cnt=3) -> current period still 5 ticks high; next period 10 ticks high.
- Reversal: dir_req[0] 0->1 while running ->
  - reversing[0]=1 and en_o[0]=0 from the next cycle;
  - dir_o[0] flips after 8 cycles;
  - en_o resumes after 8 more cycles;
  - ch1 is unaffected.
- Toggle dir_req back during DEAD2 -> after DEAD2 the FSM re-enters DEAD1, dir_o returns to 0 after 8 further cycles, then RUN.
- Hall: 7 clean sa[1] pulses (4 clk high/4 low) within one window -> at the gate end pulse_cnt[1]=7 with a single-cycle cnt_valid; an edge coincident with gate end is counted in the next window.
- Saturation with CNT_W=3: 12 edges in a window -> pulse_cnt=7. Async resetn pulse mid-reversal -> en_o, dir_o, reversing and pulse_cnt read 0 immediately; operation restarts cleanly.
